// File: rtl/wb_regfile_unit.sv
// wb_regfile_unit -- writeback stage of the 8-bit Harvard pipelined RISC core.
//
// Commits MEM/WB results into architectural state:
//   - four 8-bit general registers (R3 doubles as the stack pointer)
//   - 4-bit condition-code register {V,C,N,Z} plus a shadow copy used by
//     interrupt entry (int_save) and RTI (rti_restore)
//   - a retired-instruction counter (wraps silently)
// Two combinational read ports feed the decode stage.
//
// Build option: define WB_BYPASS_EN to forward same-cycle writeback data onto
// the read ports. Without it the read ports show stored state only.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   wb_valid          MEM/WB slot holds a real instruction
//   wb_write_enable   instruction writes wb_dest_reg with wb_data
//   wb_dest_reg       destination register index
//   wb_data           result data
//   wb_flags          new CCR value {V,C,N,Z}
//   wb_update_sp      instruction updates R3 with wb_new_sp
//   wb_new_sp         new stack pointer value
//   int_save          pulse: shadow CCR <= CCR
//   rti_restore       pulse: CCR <= shadow CCR
//   rd_addr_a/b       read port indices
//   rd_data_a/b       read port data
//   sp_out            current R3
//   flags_out         current CCR
//   retired_count     count of committed valid instructions
module wb_regfile_unit #(
  parameter logic [7:0] SP_RESET     = 8'hFF,
  parameter int         RETIRE_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wb_valid,
  input  logic                    wb_write_enable,
  input  logic [1:0]              wb_dest_reg,
  input  logic [7:0]              wb_data,
  input  logic [3:0]              wb_flags,
  input  logic                    wb_update_sp,
  input  logic [7:0]              wb_new_sp,
  input  logic                    int_save,
  input  logic                    rti_restore,
  input  logic [1:0]              rd_addr_a,
  input  logic [1:0]              rd_addr_b,
  output logic [7:0]              rd_data_a,
  output logic [7:0]              rd_data_b,
  output logic [7:0]              sp_out,
  output logic [3:0]              flags_out,
  output logic [RETIRE_CNT_W-1:0] retired_count
);

  logic [7:0]              regs_q [4];
  logic [7:0]              regs_d [4];
  logic [3:0]              ccr_q, ccr_d;
  logic [3:0]              shadow_q, shadow_d;
  logic [RETIRE_CNT_W-1:0] count_q, count_d;

  logic reg_wr;
  logic sp_wr;

  assign reg_wr = wb_valid && wb_write_enable;
  assign sp_wr  = wb_valid && wb_update_sp;

  // Next-state for the register file. The general write is applied after the
  // SP update so that a POP R3 (dest=3 with SP update) keeps wb_data.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (sp_wr) begin
      regs_d[3] = wb_new_sp;
    end
    if (reg_wr) begin
      regs_d[wb_dest_reg] = wb_data;
    end
  end

  // CCR / shadow next-state. Both sides read the pre-edge values, so a
  // simultaneous save + restore swaps CCR and shadow. Restore outranks a
  // same-cycle flags write.
  always_comb begin
    ccr_d    = ccr_q;
    shadow_d = shadow_q;
    if (wb_valid) begin
      ccr_d = wb_flags;
    end
    if (rti_restore) begin
      ccr_d = shadow_q;
    end
    if (int_save) begin
      shadow_d = ccr_q;
    end
  end

  assign count_d = count_q + RETIRE_CNT_W'(wb_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q[0] <= 8'h00;
      regs_q[1] <= 8'h00;
      regs_q[2] <= 8'h00;
      regs_q[3] <= SP_RESET;
      ccr_q     <= 4'h0;
      shadow_q  <= 4'h0;
      count_q   <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= regs_d[i];
      end
      ccr_q    <= ccr_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
    end
  end

  // Read ports, built identically for A and B.
  logic [1:0] rd_addr [2];
  logic [7:0] rd_data [2];

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd_port
`ifdef WB_BYPASS_EN
      // Forwarding priority follows the commit priority: register write
      // first, then the SP update for R3.
      always_comb begin
        rd_data[gi] = regs_q[rd_addr[gi]];
        if (reg_wr && (wb_dest_reg == rd_addr[gi])) begin
          rd_data[gi] = wb_data;
        end else if (sp_wr && (rd_addr[gi] == 2'd3)) begin
          rd_data[gi] = wb_new_sp;
        end
      end
`else
      assign rd_data[gi] = regs_q[rd_addr[gi]];
`endif
    end
  endgenerate

  assign rd_data_a     = rd_data[0];
  assign rd_data_b     = rd_data[1];
  assign sp_out        = regs_q[3];
  assign flags_out     = ccr_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_wb_regfile_unit.sv
// Directed bench for wb_regfile_unit, built with a 4-bit retire counter so the
// wrap case is reachable in a few cycles.
module tb_wb_regfile_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wb_valid;
  logic          wb_write_enable;
  logic [1:0]    wb_dest_reg;
  logic [7:0]    wb_data;
  logic [3:0]    wb_flags;
  logic          wb_update_sp;
  logic [7:0]    wb_new_sp;
  logic          int_save;
  logic          rti_restore;
  logic [1:0]    rd_addr_a;
  logic [1:0]    rd_addr_b;
  logic [7:0]    rd_data_a;
  logic [7:0]    rd_data_b;
  logic [7:0]    sp_out;
  logic [3:0]    flags_out;
  logic [CW-1:0] retired_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_regfile_unit #(.SP_RESET(8'hFF), .RETIRE_CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_write_enable(wb_write_enable),
    .wb_dest_reg(wb_dest_reg), .wb_data(wb_data), .wb_flags(wb_flags),
    .wb_update_sp(wb_update_sp), .wb_new_sp(wb_new_sp),
    .int_save(int_save), .rti_restore(rti_restore),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .sp_out(sp_out), .flags_out(flags_out), .retired_count(retired_count)
  );

  typedef struct {
    logic       valid;
    logic       we;
    logic [1:0] dest;
    logic [7:0] data;
    logic [3:0] flags;
    logic       usp;
    logic [7:0] nsp;
    logic       isave;
    logic       rti;
    logic [7:0] e0, e1, e2, e3;
    logic [3:0] ef;
    logic [3:0] ec;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    wb_valid = 0; wb_write_enable = 0; wb_dest_reg = 0; wb_data = 0;
    wb_flags = 0; wb_update_sp = 0; wb_new_sp = 0;
    int_save = 0; rti_restore = 0;
  endtask

  // Called shortly after a posedge with idle inputs; sweeps all registers
  // through both ports within half a clock period.
  task automatic check_state(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3,
                             input logic [3:0] ef, input logic [3:0] ec);
    rd_addr_a = 2'd0; rd_addr_b = 2'd1; #1;
    chk({tag, " r0"}, rd_data_a, e0);
    chk({tag, " r1"}, rd_data_b, e1);
    rd_addr_a = 2'd2; rd_addr_b = 2'd3; #1;
    chk({tag, " r2"}, rd_data_a, e2);
    chk({tag, " r3"}, rd_data_b, e3);
    chk({tag, " sp"}, sp_out, e3);
    chk({tag, " flags"}, flags_out, ef);
    chk({tag, " cnt"}, retired_count, ec);
  endtask

  task automatic step();
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    // valid we dest data flags usp nsp isave rti | r0 r1 r2 r3 flags cnt
    tbl[0]  = '{1,1,2'd2,8'h5A,4'h5,0,8'h00,0,0, 8'h00,8'h00,8'h5A,8'hFF,4'h5,4'd1};
    tbl[1]  = '{0,1,2'd2,8'h33,4'h9,1,8'h80,0,0, 8'h00,8'h00,8'h5A,8'hFF,4'h5,4'd1};
    tbl[2]  = '{1,1,2'd3,8'h12,4'hC,1,8'hFE,0,0, 8'h00,8'h00,8'h5A,8'h12,4'hC,4'd2};
    tbl[3]  = '{1,0,2'd3,8'h00,4'hA,1,8'hFD,0,0, 8'h00,8'h00,8'h5A,8'hFD,4'hA,4'd3};
    tbl[4]  = '{0,0,2'd0,8'h00,4'h0,0,8'h00,1,0, 8'h00,8'h00,8'h5A,8'hFD,4'hA,4'd3};
    tbl[5]  = '{1,1,2'd0,8'h11,4'h3,0,8'h00,0,0, 8'h11,8'h00,8'h5A,8'hFD,4'h3,4'd4};
    tbl[6]  = '{1,1,2'd1,8'h22,4'hF,0,8'h00,0,1, 8'h11,8'h22,8'h5A,8'hFD,4'hA,4'd5};
    tbl[7]  = '{1,0,2'd0,8'h00,4'h6,0,8'h00,0,0, 8'h11,8'h22,8'h5A,8'hFD,4'h6,4'd6};
    tbl[8]  = '{0,0,2'd0,8'h00,4'h0,0,8'h00,1,1, 8'h11,8'h22,8'h5A,8'hFD,4'hA,4'd6};
    tbl[9]  = '{0,0,2'd0,8'h00,4'h0,0,8'h00,0,1, 8'h11,8'h22,8'h5A,8'hFD,4'h6,4'd6};
    tbl[10] = '{1,0,2'd0,8'h00,4'h1,0,8'h00,1,0, 8'h11,8'h22,8'h5A,8'hFD,4'h1,4'd7};
    tbl[11] = '{0,0,2'd0,8'h00,4'h0,0,8'h00,0,1, 8'h11,8'h22,8'h5A,8'hFD,4'h6,4'd7};

    idle();
    rd_addr_a = 0; rd_addr_b = 0;
    reset = 1;
    @(negedge clk); @(negedge clk);
    reset = 0;
    @(negedge clk); @(negedge clk);
    // Reset then idle: nothing may have moved during the idle cycles.
    #0 check_state("reset", 8'h00, 8'h00, 8'h00, 8'hFF, 4'h0, 4'd0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      wb_valid = tbl[i].valid; wb_write_enable = tbl[i].we;
      wb_dest_reg = tbl[i].dest; wb_data = tbl[i].data; wb_flags = tbl[i].flags;
      wb_update_sp = tbl[i].usp; wb_new_sp = tbl[i].nsp;
      int_save = tbl[i].isave; rti_restore = tbl[i].rti;
      step();
      check_state($sformatf("vec%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].e2,
                  tbl[i].e3, tbl[i].ef, tbl[i].ec);
      $display("vec %0d: r=%h %h %h %h flags=%h cnt=%0d", i, tbl[i].e0, tbl[i].e1,
               tbl[i].e2, tbl[i].e3, tbl[i].ef, tbl[i].ec);
    end

    // Counter wrap: 7 -> 15 with eight valid no-write cycles, then one more -> 0.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wb_valid = 1; wb_flags = 4'h0;
      step();
    end
    chk("cnt at max", retired_count, 4'hF);
    @(negedge clk);
    wb_valid = 1; wb_flags = 4'h0;
    step();
    chk("cnt wrap", retired_count, 4'h0);
    $display("wrap: cnt=%0d", retired_count);

    // Reset with a valid write present; shadow currently holds 6, so a
    // following RTI exposes whether the shadow was cleared.
    @(negedge clk);
    reset = 1;
    wb_valid = 1; wb_write_enable = 1; wb_dest_reg = 2'd0; wb_data = 8'h99;
    wb_flags = 4'hB; wb_update_sp = 1; wb_new_sp = 8'h10; int_save = 1;
    step();
    reset = 0;
    check_state("midreset", 8'h00, 8'h00, 8'h00, 8'hFF, 4'h0, 4'd0);
    @(negedge clk);
    rti_restore = 1;
    step();
    chk("shadow reset", flags_out, 4'h0);
    $display("midreset: flags=%h cnt=%0d", flags_out, retired_count);

    // Same-cycle read of a register being written.
    @(negedge clk);
    rd_addr_a = 2'd1; rd_addr_b = 2'd3;
    wb_valid = 1; wb_write_enable = 1; wb_dest_reg = 2'd1; wb_data = 8'h77;
    wb_update_sp = 1; wb_new_sp = 8'h44; wb_flags = 4'h2;
    #1;
`ifdef WB_BYPASS_EN
    chk("bypass a", rd_data_a, 8'h77);
    chk("bypass b sp", rd_data_b, 8'h44);
`else
    chk("nobypass a", rd_data_a, 8'h00);
    chk("nobypass b sp", rd_data_b, 8'hFF);
`endif
    step();
    rd_addr_a = 2'd1; rd_addr_b = 2'd3; #1;
    chk("post a", rd_data_a, 8'h77);
    chk("post b", rd_data_b, 8'h44);
    chk("post cnt", retired_count, 4'd1);
    $display("bypass seq: a=%h b=%h", rd_data_a, rd_data_b);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

endmodule
